// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Issues one outstanding request at a time to instruction memory, holds IF/ID
// under stall (buffering any instruction that lands meanwhile), and on a flush
// redirects the PC, drops stale responses and injects a bubble.
// Optional feature macro: FETCH_PERF_CNT_EN (stall-cycle and flush counters).
// Handshake: imem_req_op is a strobe that memory accepts in the same cycle;
// each accepted request returns exactly one imem_rvalid_ip pulse, in order,
// at least one cycle later. No backpressure from memory.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        flush_ip,
  input  logic [31:0] redirect_pc_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic [31:0] ID_instr_op,
  output logic [31:0] ID_pc_op,
  output logic        ID_valid_op,
  output logic        fetch_busy_op,
  output logic [31:0] perf_stall_cyc_op,
  output logic [31:0] perf_flush_cnt_op,
  output logic [1:0]  dbg_state_op
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] id_instr, id_instr_nxt;
  logic [31:0] id_pc, id_pc_nxt;
  logic        id_valid, id_valid_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        req;
  logic [31:0] pc_inc;

  assign pc_inc = pc + 32'd4;

  // State, PC, IF/ID and hold-buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      id_instr   <= NOP_INSTR;
      id_pc      <= 32'd0;
      id_valid   <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'd0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      id_instr   <= id_instr_nxt;
      id_pc      <= id_pc_nxt;
      id_valid   <= id_valid_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_valid <= hold_valid_nxt;
    end
  end

  // Next-state, request strobe and IF/ID update; flush outranks everything.
  // The fetch address follows the PC, including the advanced PC in cycles
  // that accept an instruction and immediately issue the next fetch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    id_instr_nxt   = id_instr;
    id_pc_nxt      = id_pc;
    id_valid_nxt   = id_valid;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    hold_valid_nxt = hold_valid;
    req            = 1'b0;
    imem_addr_op   = pc;
    if (flush_ip) begin
      pc_nxt         = redirect_pc_ip;
      id_valid_nxt   = 1'b0;
      id_instr_nxt   = NOP_INSTR;
      hold_valid_nxt = 1'b0;
      // A request still in flight must be drained before refetching.
      if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid_ip)
        state_nxt = S_DRAIN;
      else
        state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          req       = 1'b1;
          state_nxt = S_WAIT;
          if (!stall_ip) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_ip && !stall_ip) begin
            id_instr_nxt = imem_rdata_ip;
            id_pc_nxt    = pc;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc_inc;
            req          = 1'b1;
            imem_addr_op = pc_inc;
          end else if (imem_rvalid_ip) begin
            hold_instr_nxt = imem_rdata_ip;
            hold_pc_nxt    = pc;
            hold_valid_nxt = 1'b1;
            state_nxt      = S_HOLD;
          end else if (!stall_ip) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stall_ip) begin
            id_instr_nxt   = hold_instr;
            id_pc_nxt      = hold_pc;
            id_valid_nxt   = hold_valid;
            hold_valid_nxt = 1'b0;
            pc_nxt         = pc_inc;
            req            = 1'b1;
            imem_addr_op   = pc_inc;
            state_nxt      = S_WAIT;
          end
        end
        default: begin
          // S_DRAIN: the stale response is swallowed; IF/ID stays a bubble.
          id_valid_nxt = 1'b0;
          id_instr_nxt = NOP_INSTR;
          if (imem_rvalid_ip) state_nxt = S_REQ;
        end
      endcase
    end
  end

  assign imem_req_op   = req & ~reset;
  assign fetch_busy_op = (state == S_WAIT) || (state == S_DRAIN);
  assign ID_instr_op   = id_instr;
  assign ID_pc_op      = id_pc;
  assign ID_valid_op   = id_valid;
  assign dbg_state_op  = state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cyc;
  logic [31:0] flush_cnt;

  // Saturating stall-cycle and flush-event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_ip && stall_cyc != 32'hFFFF_FFFF) stall_cyc <= stall_cyc + 32'd1;
      if (flush_ip && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cyc_op = stall_cyc;
  assign perf_flush_cnt_op = flush_cnt;
`else
  assign perf_stall_cyc_op = 32'd0;
  assign perf_flush_cnt_op = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: bench for fetch_stage with an in-order memory model and a
// program-order scoreboard of the instructions decode should consume.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req_op, ID_valid_op, fetch_busy_op;
  logic [31:0] imem_addr_op, ID_instr_op, ID_pc_op, perf_stall_cyc_op, perf_flush_cnt_op;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int idle = 0;
  int perf_stall_m = 0;
  int perf_flush_m = 0;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  logic [63:0] exp_q[$];
  logic        samp_req, samp_rvalid;
  logic [31:0] samp_addr;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_ip(stall), .flush_ip(flush),
    .redirect_pc_ip(redirect_pc), .imem_req_op(imem_req_op), .imem_addr_op(imem_addr_op),
    .imem_rvalid_ip(rvalid), .imem_rdata_ip(rdata), .ID_instr_op(ID_instr_op),
    .ID_pc_op(ID_pc_op), .ID_valid_op(ID_valid_op), .fetch_busy_op(fetch_busy_op),
    .perf_stall_cyc_op(perf_stall_cyc_op), .perf_flush_cnt_op(perf_flush_cnt_op),
    .dbg_state_op(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // One clock cycle: drive memory response, check, clock, update models.
  task automatic step();
    logic        c_stall, c_flush, c_reset, p_valid;
    logic [31:0] p_instr, p_pc;
    logic [63:0] e;
    int          outstanding;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (!reset && pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_addr[0]);
    end
    #3;
    samp_req = imem_req_op; samp_addr = imem_addr_op; samp_rvalid = rvalid;
    c_stall = stall; c_flush = flush; c_reset = reset;
    p_valid = ID_valid_op; p_instr = ID_instr_op; p_pc = ID_pc_op;
    if (c_reset) begin
      vectors++;
      if (samp_req !== 1'b0) begin miscompares++; $display("FAIL req_in_reset got=%b exp=0", samp_req); end
      perf_stall_m = 0; perf_flush_m = 0;
    end else begin
      if (c_stall) perf_stall_m++;
      if (c_flush) perf_flush_m++;
      vectors++;
      if (fetch_busy_op !== (pend_addr.size() != 0)) begin
        miscompares++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, fetch_busy_op, pend_addr.size() != 0);
      end
      outstanding = pend_addr.size() - (samp_rvalid ? 1 : 0);
      if (samp_req) begin
        vectors++;
        if (outstanding != 0) begin miscompares++; $display("FAIL single_outstanding cyc=%0d got=%0d exp=0", cyc, outstanding); end
      end
      if (!p_valid) begin
        vectors++;
        if (p_instr !== NOP) begin miscompares++; $display("FAIL bubble_instr cyc=%0d got=%h exp=%h", cyc, p_instr, NOP); end
      end
      if (!c_flush && !c_stall && p_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL consume cyc=%0d got=%h exp=<none>", cyc, p_pc);
        end else begin
          e = exp_q.pop_front();
          if ({p_pc, p_instr} !== e) begin
            miscompares++; $display("FAIL consume cyc=%0d got=%h/%h exp=%h/%h", cyc, p_pc, p_instr, e[63:32], e[31:0]);
          end
          exp_q.push_back({e[63:32] + 32'd4, mem_word(e[63:32] + 32'd4)});
        end
        idle = 0;
      end else if (!c_flush && !c_stall) begin
        idle++;
        vectors++;
        if (idle > 16) begin miscompares++; $display("FAIL progress cyc=%0d got=%0d idle cycles exp<=16", cyc, idle); idle = 0; end
      end
      if (c_flush) begin
        exp_q.delete();
        exp_q.push_back({redirect_pc, mem_word(redirect_pc)});
        idle = 0;
      end
    end
    @(posedge clk);
    #1;
    if (c_reset) begin
      pend_addr.delete(); pend_rdy.delete(); exp_q.delete();
      exp_q.push_back({RESET_PC, mem_word(RESET_PC)});
      idle = 0;
      vectors++;
      if (ID_valid_op !== 1'b0 || ID_instr_op !== NOP || ID_pc_op !== 32'd0) begin
        miscompares++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/%h/0", ID_valid_op, ID_instr_op, ID_pc_op, NOP);
      end
    end else begin
      if (samp_rvalid) begin void'(pend_addr.pop_front()); void'(pend_rdy.pop_front()); end
      if (samp_req) begin pend_addr.push_back(samp_addr); pend_rdy.push_back(cyc + $urandom_range(lat_max, lat_min)); end
      if (c_flush) begin
        vectors++;
        if (ID_valid_op !== 1'b0 || ID_instr_op !== NOP) begin
          miscompares++; $display("FAIL flush_bubble cyc=%0d got=%b/%h exp=0/%h", cyc, ID_valid_op, ID_instr_op, NOP);
        end
      end else if (c_stall) begin
        vectors++;
        if ({ID_valid_op, ID_instr_op, ID_pc_op} !== {p_valid, p_instr, p_pc}) begin
          miscompares++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, {ID_valid_op, ID_instr_op, ID_pc_op}, {p_valid, p_instr, p_pc});
        end
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    lat_min = 1; lat_max = 1;
    step(); step();
    reset = 1'b0;
    vectors++; if (ID_valid_op !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", ID_valid_op); end
    vectors++; if (ID_instr_op !== NOP) begin miscompares++; $display("FAIL rst_instr got=%h exp=%h", ID_instr_op, NOP); end
    vectors++; if (ID_pc_op !== 32'd0) begin miscompares++; $display("FAIL rst_pc got=%h exp=0", ID_pc_op); end
    vectors++; if (fetch_busy_op !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", fetch_busy_op); end
    vectors++; if (imem_addr_op !== RESET_PC) begin miscompares++; $display("FAIL rst_addr got=%h exp=%h", imem_addr_op, RESET_PC); end
    step();
    vectors++; if (samp_req !== 1'b1 || samp_addr !== RESET_PC) begin miscompares++; $display("FAIL first_req got=%b/%h exp=1/%h", samp_req, samp_addr, RESET_PC); end
  endtask

  task automatic test_back_to_back();
    step();
    vectors++; if (samp_req !== 1'b1 || samp_addr !== 32'h4) begin miscompares++; $display("FAIL b2b_req4 got=%b/%h exp=1/4", samp_req, samp_addr); end
    vectors++; if (ID_valid_op !== 1'b1 || ID_pc_op !== 32'h0 || ID_instr_op !== mem_word(32'h0)) begin
      miscompares++; $display("FAIL b2b_id0 got=%b/%h/%h exp=1/0/%h", ID_valid_op, ID_pc_op, ID_instr_op, mem_word(32'h0)); end
    step();
    vectors++; if (samp_req !== 1'b1 || samp_addr !== 32'h8) begin miscompares++; $display("FAIL b2b_req8 got=%b/%h exp=1/8", samp_req, samp_addr); end
    vectors++; if (ID_valid_op !== 1'b1 || ID_pc_op !== 32'h4) begin miscompares++; $display("FAIL b2b_id4 got=%b/%h exp=1/4", ID_valid_op, ID_pc_op); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (samp_req !== 1'b0) begin miscompares++; $display("FAIL stall_req i=%0d got=%b exp=0", i, samp_req); end
      vectors++; if (imem_addr_op !== 32'h8) begin miscompares++; $display("FAIL stall_pc i=%0d got=%h exp=8", i, imem_addr_op); end
      vectors++; if (ID_valid_op !== 1'b1 || ID_pc_op !== 32'h4) begin miscompares++; $display("FAIL stall_id i=%0d got=%b/%h exp=1/4", i, ID_valid_op, ID_pc_op); end
    end
    stall = 1'b0;
    step();
    vectors++; if (samp_req !== 1'b1 || samp_addr !== 32'hC) begin miscompares++; $display("FAIL unstall_req got=%b/%h exp=1/c", samp_req, samp_addr); end
    vectors++; if (ID_valid_op !== 1'b1 || ID_pc_op !== 32'h8 || ID_instr_op !== 32'h0050_0093) begin
      miscompares++; $display("FAIL unstall_id got=%b/%h/%h exp=1/8/00500093", ID_valid_op, ID_pc_op, ID_instr_op); end
    step();
    vectors++; if (ID_valid_op !== 1'b1 || ID_pc_op !== 32'hC) begin miscompares++; $display("FAIL unstall_next got=%b/%h exp=1/c", ID_valid_op, ID_pc_op); end
  endtask

  task automatic test_flush_drain();
    bit found, seen;
    reset = 1'b1; step(); reset = 1'b0;
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (samp_req && samp_addr == 32'h10) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL drain_setup got=no req @10 exp=req @10"); end
    flush = 1'b1; redirect_pc = 32'h100;
    step();
    flush = 1'b0;
    vectors++; if (samp_req !== 1'b0) begin miscompares++; $display("FAIL drain_flush_req got=%b exp=0", samp_req); end
    vectors++; if (fetch_busy_op !== 1'b1) begin miscompares++; $display("FAIL drain_busy got=%b exp=1", fetch_busy_op); end
    seen = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (samp_req && !seen) begin
        seen = 1'b1;
        vectors++; if (samp_addr !== 32'h100) begin miscompares++; $display("FAIL drain_next_addr got=%h exp=100", samp_addr); end
      end
      if (ID_valid_op) found = 1'b1;
    end
    vectors++; if (!found || ID_pc_op !== 32'h100 || ID_instr_op !== mem_word(32'h100)) begin
      miscompares++; $display("FAIL drain_first_id got=%b/%h/%h exp=1/100/%h", found, ID_pc_op, ID_instr_op, mem_word(32'h100)); end
  endtask

  task automatic test_flush_stall();
    bit found;
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h200;
    step();
    stall = 1'b0; flush = 1'b0;
    vectors++; if (ID_valid_op !== 1'b0 || ID_instr_op !== NOP) begin
      miscompares++; $display("FAIL fs_bubble got=%b/%h exp=0/%h", ID_valid_op, ID_instr_op, NOP); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (samp_req) begin
        found = 1'b1;
        vectors++; if (samp_addr !== 32'h200) begin miscompares++; $display("FAIL fs_next_addr got=%h exp=200", samp_addr); end
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL fs_timeout got=no req exp=req @200"); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    lat_min = 1; lat_max = 1;
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    for (int i = 0; i < 30 && addrs.size() < 2; i++) begin
      step();
      if (samp_req) addrs.push_back(samp_addr);
    end
    vectors++;
    if (addrs.size() < 2) begin miscompares++; $display("FAIL wrap_timeout got=%0d reqs exp=2", addrs.size()); end
    else if (addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      miscompares++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", addrs[0], addrs[1]); end
  endtask

  task automatic test_perf();
    reset = 1'b1; step(); reset = 1'b0;
    lat_min = 1; lat_max = 2;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall = 1'b0; flush = 1'b1; redirect_pc = 32'h40;
    for (int i = 0; i < 2; i++) step();
    flush = 1'b0;
    step();
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (perf_stall_cyc_op !== 32'd5) begin miscompares++; $display("FAIL perf_stall got=%0d exp=5", perf_stall_cyc_op); end
    vectors++; if (perf_flush_cnt_op !== 32'd2) begin miscompares++; $display("FAIL perf_flush got=%0d exp=2", perf_flush_cnt_op); end
`else
    vectors++; if (perf_stall_cyc_op !== 32'd0) begin miscompares++; $display("FAIL perf_stall_off got=%0d exp=0", perf_stall_cyc_op); end
    vectors++; if (perf_flush_cnt_op !== 32'd0) begin miscompares++; $display("FAIL perf_flush_off got=%0d exp=0", perf_flush_cnt_op); end
`endif
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199, 0) == 0);
      stall = ($urandom_range(99, 0) < 30);
      flush = ($urandom_range(99, 0) < 6);
      redirect_pc = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      step();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 20; i++) step();
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (perf_stall_cyc_op !== perf_stall_m) begin miscompares++; $display("FAIL rnd_perf_stall got=%0d exp=%0d", perf_stall_cyc_op, perf_stall_m); end
    vectors++; if (perf_flush_cnt_op !== perf_flush_m) begin miscompares++; $display("FAIL rnd_perf_flush got=%0d exp=%0d", perf_flush_cnt_op, perf_flush_m); end
`else
    vectors++; if (perf_stall_cyc_op !== 32'd0 || perf_flush_cnt_op !== 32'd0) begin
      miscompares++; $display("FAIL rnd_perf_off got=%0d/%0d exp=0/0", perf_stall_cyc_op, perf_flush_cnt_op); end
`endif
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and report.
  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    rvalid = 1'b0; rdata = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush_drain();
    test_flush_stall();
    test_wrap();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
